// File: rtl/dice_roller_pkg.sv
// Shared constants for the dice roller: die encodings, LFSR seed/taps and
// the die-type to number-of-sides decode.
package dice_roller_pkg;

    typedef enum logic [1:0] {
        DIE_D4  = 2'b00,
        DIE_D6  = 2'b01,
        DIE_D8  = 2'b10,
        DIE_D20 = 2'b11
    } die_e;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (shift-left form)
    localparam int unsigned TAP_A = 15;
    localparam int unsigned TAP_B = 13;
    localparam int unsigned TAP_C = 12;
    localparam int unsigned TAP_D = 10;

    function automatic logic [4:0] sides_of(input logic [1:0] sel);
        logic [4:0] sides;
        case (sel)
            DIE_D4:  sides = 5'd4;
            DIE_D6:  sides = 5'd6;
            DIE_D8:  sides = 5'd8;
            default: sides = 5'd20;
        endcase
        return sides;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, reloads SEED on
// synchronous reset.
module lfsr16
    import dice_roller_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    logic [15:0] r_state;
    logic        w_feedback;

    assign w_feedback = r_state[TAP_A] ^ r_state[TAP_B] ^ r_state[TAP_C] ^ r_state[TAP_D];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[14:0], w_feedback};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/dice_roller.sv
// Dice roller: scales the low LFSR byte onto 1..sides and registers the face
// whenever roll is sampled high. 0 on the output means "no roll since reset".
module dice_roller
    import dice_roller_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] die_select,
    input  logic       roll,
    output logic [7:0] rolled_number
);

    logic [15:0] w_lfsr;
    logic [7:0]  w_lfsr_lo;
    logic [7:0]  w_unused_lfsr_hi;
    logic [4:0]  w_sides;
    logic [12:0] w_product;
    logic [7:0]  w_face;
    logic [7:0]  r_rolled;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .state(w_lfsr)
    );

    assign {w_unused_lfsr_hi, w_lfsr_lo} = w_lfsr;

    // Multiply-and-shift keeps d4/d8 exactly uniform; product max 255*20 fits 13 bits
    assign w_sides   = sides_of(die_select);
    assign w_product = {5'b0, w_lfsr_lo} * {8'b0, w_sides};
    assign w_face    = {3'b0, w_product[12:8]} + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rolled <= '0;
        end else if (roll) begin
            r_rolled <= w_face;
        end
    end

    assign rolled_number = r_rolled;

endmodule

// File: tb/tb_dice_roller.sv
// Randomized self-checking bench for dice_roller against an arithmetic
// reference model of the LFSR and face scaling.
module tb_dice_roller;

    localparam int unsigned SEED = 16'hACE1;
    localparam int unsigned NRAND = 1000;
    localparam int unsigned NREPLAY = 200;

    logic       clk;
    logic       reset;
    logic [1:0] die_select;
    logic       roll;
    logic [7:0] rolled_number;

    int unsigned n_checks;
    int unsigned n_errors;

    int unsigned m_lfsr;
    int unsigned m_out;
    int unsigned sides_tab [4] = '{4, 6, 8, 20};

    logic       st_roll [NRAND];
    logic [1:0] st_sel  [NRAND];
    int unsigned rec_out [NRAND];

    dice_roller #(
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .die_select   (die_select),
        .roll         (roll),
        .rolled_number(rolled_number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned model_next(input int unsigned s);
        int unsigned fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) % 2;
        return ((s * 2) % 65536) + fb;
    endfunction

    function automatic int unsigned model_face(input int unsigned s, input int unsigned sel);
        return ((s % 256) * sides_tab[sel]) / 256 + 1;
    endfunction

    // Apply inputs, take one rising edge, advance the model, sample 1ns later.
    task automatic step(input logic rst, input logic rl, input logic [1:0] sel);
        reset      = rst;
        roll       = rl;
        die_select = sel;
        @(posedge clk);
        if (rst) begin
            m_lfsr = SEED;
            m_out  = 0;
        end else begin
            if (rl) m_out = model_face(m_lfsr, int'(sel));
            m_lfsr = model_next(m_lfsr);
        end
        #1;
    endtask

    initial begin
        int unsigned held;
        bit seen [21];
        int unsigned nseen;

        n_checks = 0;
        n_errors = 0;
        m_lfsr = SEED;
        m_out = 0;
        reset = 1'b1;
        roll = 1'b0;
        die_select = 2'b00;

        // Reset then idle: output stays 0
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 2'($urandom_range(0, 3)));
            check("reset_zero", rolled_number, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            check("idle_zero", rolled_number, 0);
        end

        // Range and face coverage per die
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b0, 2'(d));
            for (int f = 0; f < 21; f++) seen[f] = 1'b0;
            for (int i = 0; i < 200; i++) begin
                step(1'b0, 1'b1, 2'(d));
                check("range", int'(rolled_number >= 1 && rolled_number <= sides_tab[d]), 1);
                check("cov_model", rolled_number, m_out);
                if (rolled_number <= 20) seen[rolled_number] = 1'b1;
            end
            nseen = 0;
            for (int f = 1; f <= 20; f++) if (seen[f]) nseen++;
            check("all_faces", nseen, sides_tab[d]);
        end

        // Single roll then hold while die_select toggles
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b01);
        held = m_out;
        check("roll_d6", rolled_number, held);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 2'(i % 4));
            check("hold", rolled_number, held);
        end

        // Random roll/die_select against the model, recording the run
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < int'(NRAND); i++) begin
            st_roll[i] = 1'($urandom_range(0, 1));
            st_sel[i]  = 2'($urandom_range(0, 3));
            step(1'b0, st_roll[i], st_sel[i]);
            rec_out[i] = rolled_number;
            check("rand_model", rolled_number, m_out);
        end

        // Reset mid-run with roll high, then replay and expect the same results
        step(1'b1, 1'b1, 2'b11);
        check("reset_dominates", rolled_number, 0);
        for (int i = 0; i < int'(NREPLAY); i++) begin
            step(1'b0, st_roll[i], st_sel[i]);
            check("replay", rolled_number, rec_out[i]);
            check("replay_model", rolled_number, m_out);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, SHALL set the LFSR reset value; it SHALL be non-zero.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge only.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port die_select, input, 2 bits: die type. 00 = d4, 01 = d6, 10 = d8, 11 = d20.
REQ-005 Port roll, input, 1 bit: level-sensitive roll request, sampled on each rising edge.
REQ-006 Port rolled_number, output, 8 bits, registered: last rolled face value, unsigned.

Function
REQ-007 A 16-bit Fibonacci LFSR SHALL advance every clock cycle while reset is low:
- Polynomial x^16+x^14+x^13+x^11+1.
- Shift left; new bit0 = b15^b13^b12^b10.
REQ-008 The LFSR SHALL advance regardless of roll, so the outcome depends on roll timing.
REQ-009 Sides SHALL be decoded from die_select as 4, 6, 8 or 20.
REQ-010 Face value SHALL be ((lfsr[7:0] * sides) >> 8) + 1, using the pre-update LFSR value of that edge. The product is 13 bits; no overflow.
REQ-011 The face value SHALL always lie in 1..sides.
REQ-012 On a rising edge with reset low and roll high:
- die_select SHALL be sampled on that same edge.
- rolled_number SHALL load the face value, with one-edge latency.
REQ-013 Roll held high for N cycles SHALL produce N successive updates, one per edge.
REQ-014 On any edge with roll low, rolled_number SHALL hold its value.
REQ-015 A die_select change alone SHALL NOT alter rolled_number.
REQ-016 A die_select change together with roll high SHALL apply the new die on that same edge.
REQ-017 The d4 and d8 results SHALL be exactly uniform over the 8-bit LFSR slice. The d6 and d20 results SHALL be uniform within one count in 256.

Reset
REQ-018 With reset high on a rising edge:
- rolled_number SHALL become 8'd0.
- The LFSR SHALL load LFSR_SEED.
REQ-019 Reset SHALL dominate roll; a roll sampled during reset SHALL be discarded.
REQ-020 A reset asserted mid-sequence SHALL restart the identical LFSR sequence, giving deterministic, repeatable results.
REQ-021 The value 0 on rolled_number SHALL mean "no roll since reset". It SHALL never be produced by a roll.

Structure
REQ-022 Package dice_roller_pkg SHALL hold:
- die_select encoding constants (DIE_D4, DIE_D6, DIE_D8, DIE_D20);
- the sides lookup function;
- the default seed;
- the tap positions.
REQ-023 Sub-module lfsr16 SHALL implement the LFSR (inputs clk, reset; output state[15:0]; parameter SEED).
REQ-024 The top level SHALL implement the sides decode, the scaling multiply and the output register.
REQ-025 There SHALL be no latches, no asynchronous logic and no combinational path from inputs to rolled_number.

Verification
REQ-026 Reset for 2 cycles with roll=0, then 5 idle cycles -> rolled_number = 0 throughout.
REQ-027 After reset, roll=1 for 200 cycles on each of die_select 00, 01, 10, 11 -> every sample lies in 1..4, 1..6, 1..8, 1..20 respectively, and every face occurs at least once.
REQ-028 After reset, roll=1 for one cycle with die_select=01, then roll=0 for 10 cycles while die_select toggles -> rolled_number stays constant at the value loaded on the roll edge.
REQ-029 A bit-accurate bench model (seed 16'hACE1) run alongside the DUT for 1000 random roll/die_select cycles -> rolled_number matches the model on every edge.
REQ-030 Reset asserted mid-run with roll=1 -> rolled_number = 0 on the next edge. After release, the identical result sequence from the first run repeats.
REQ-031 roll=1 and reset=1 on the same edge -> rolled_number = 0.
